// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver: one push per rising edge of i_rxFinished.
// Optional build macro UART_RX_FIFO_DROP_PERR_EN discards parity-error frames at the write port.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rxFinished,
  input  logic [7:0]    i_rxBits,
  input  logic          i_parityError,
  input  logic          i_rdEn,
  input  logic          i_clrOverflow,
  output logic [7:0]    o_rdData,
  output logic          o_rdPerr,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow
);

`ifdef UART_RX_FIFO_DROP_PERR_EN
  localparam int EW = 8;
`else
  localparam int EW = 9;
`endif

  logic [EW-1:0] mem [DEPTH];

  logic          fin_prev_q, fin_prev_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          wr_edge;
  logic          wr_req;
  logic          rd_ok;
  logic          push_ok;
  logic          drop;
  logic          is_empty;
  logic          is_full;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    wr_edge = i_rxFinished & ~fin_prev_q;
`ifdef UART_RX_FIFO_DROP_PERR_EN
    wr_req   = wr_edge & ~i_parityError;
    wr_entry = i_rxBits;
`else
    wr_req   = wr_edge;
    wr_entry = {i_parityError, i_rxBits};
`endif
    rd_ok   = i_rdEn & ~is_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok = wr_req & (~is_full | rd_ok);
    drop    = wr_req & is_full & ~rd_ok;
  end

  always_comb begin
    fin_prev_d = i_rxFinished;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push_ok && !rd_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_clrOverflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fin_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      fin_prev_q <= fin_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; stale contents are masked by the empty check on the read side.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  assign head_entry = mem[rd_ptr_q];

  always_comb begin
    o_rdData = is_empty ? 8'h00 : head_entry[7:0];
`ifdef UART_RX_FIFO_DROP_PERR_EN
    o_rdPerr = 1'b0;
`else
    o_rdPerr = ~is_empty & head_entry[8];
`endif
  end

  assign o_empty    = is_empty;
  assign o_full     = is_full;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef UART_RX_FIFO_DROP_PERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fin = 1'b0;
  logic [7:0]    bits = 8'h00;
  logic          perr = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rxFinished  (fin),
    .i_rxBits      (bits),
    .i_parityError (perr),
    .i_rdEn        (rd_en),
    .i_clrOverflow (clr),
    .o_rdData      (rd_data),
    .o_rdPerr      (rd_perr),
    .o_empty       (empty),
    .o_full        (full),
    .o_count       (count),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {perr, byte} entries.
  logic [8:0] m_q[$];
  bit         m_prev = 1'b0;
  bit         m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_prev = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      bit is_edge;
      bit dropped;
      is_edge = fin && !m_prev;
      dropped = 1'b0;
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (is_edge && !(DROP && perr)) begin
        if (m_q.size() < DEPTH) m_q.push_back({perr, bits});
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_prev = fin;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      int n;
      logic [8:0] head;
      n = m_q.size();
      head = (n > 0) ? m_q[0] : 9'h000;
      check("model_count",    32'(count),    32'(n));
      check("model_empty",    32'(empty),    32'(n == 0));
      check("model_full",     32'(full),     32'(n == DEPTH));
      check("model_rdData",   32'(rd_data),  32'(head[7:0]));
      check("model_rdPerr",   32'(rd_perr),  32'(head[8]));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic push(input logic [7:0] b, input logic p);
    @(negedge clk); #1;
    fin = 1'b1; bits = b; perr = p;
    @(negedge clk); #1;
    fin = 1'b0; perr = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    @(negedge clk); #1;
    check("pop_head", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_data",  32'(rd_data), 32'd0);
    check("reset_ovf",   32'(overflow), 32'd0);

    // Level held for 5 cycles pushes once.
    @(negedge clk); #1;
    fin = 1'b1; bits = 8'hA5;
    repeat (5) @(negedge clk);
    #1 fin = 1'b0;
    check("held_count", 32'(count), 32'd1);
    check("held_data",  32'(rd_data), 32'hA5);
    check("held_empty", 32'(empty), 32'd0);
    pop_expect(8'hA5);
    check("pop_empty", 32'(empty), 32'd1);
    check("pop_data0", 32'(rd_data), 32'd0);
    // Read while empty is ignored.
    pop_expect(8'h00);
    check("empty_rd_count", 32'(count), 32'd0);

    // Fill, overflow, set-wins-over-clear, drain in order.
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    push(8'h10, 1'b0);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    @(negedge clk); #1;
    fin = 1'b1; bits = 8'h11; clr = 1'b1;
    @(negedge clk); #1;
    fin = 1'b0; clr = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_expect(8'(i));
    check("drain_empty", 32'(empty), 32'd1);
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle.
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    @(negedge clk); #1;
    fin = 1'b1; bits = 8'h55; rd_en = 1'b1;
    @(negedge clk); #1;
    fin = 1'b0; rd_en = 1'b0;
    check("fullrw_count", 32'(count), 32'd16);
    check("fullrw_ovf",   32'(overflow), 32'd0);
    for (int i = 1; i < DEPTH; i++) pop_expect(8'(i));
    pop_expect(8'h55);
    check("fullrw_empty", 32'(empty), 32'd1);

    // Empty FIFO: push with read enable in the same cycle.
    @(negedge clk); #1;
    fin = 1'b1; bits = 8'h3C; rd_en = 1'b1;
    @(negedge clk); #1;
    fin = 1'b0; rd_en = 1'b0;
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_data",  32'(rd_data), 32'h3C);
    pop_expect(8'h3C);

    // Parity-error frame.
    push(8'h81, 1'b1);
`ifdef UART_RX_FIFO_DROP_PERR_EN
    check("perr_dropped", 32'(count), 32'd0);
`else
    check("perr_flag", 32'(rd_perr), 32'd1);
    check("perr_data", 32'(rd_data), 32'h81);
    pop_expect(8'h81);
`endif

    // Asynchronous reset with entries stored.
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1'b0);
    check("pre_rst_count", 32'(count), 32'd5);
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full",  32'(full), 32'd0);
    check("arst_data",  32'(rd_data), 32'd0);
    check("arst_perr",  32'(rd_perr), 32'd0);
    check("arst_ovf",   32'(overflow), 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    push(8'h77, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_data",  32'(rd_data), 32'h77);
    pop_expect(8'h77);

    repeat (2) @(negedge clk);
    #1 done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
